// File: rtl/word_to_bytes_pkg.sv
// Shared constants for the byte<->word packer/serializer pair.
// The packer and the serializer must agree on these values so a loopback returns the original stream.
package word_to_bytes_pkg;

  localparam int BYTE_W          = 8;
  localparam int N_BYTES_DEFAULT = 9;
  localparam int WORD_W          = N_BYTES_DEFAULT * BYTE_W;

  // The byte index needs at least one bit, even when a word holds a single byte.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/word_to_bytes_if.sv
// Word-in / byte-out handshake bundle for the serializer.
// The master modport is the side that offers words and sinks bytes.
interface word_to_bytes_if
  import word_to_bytes_pkg::*;
#(
  parameter int N_BYTES = N_BYTES_DEFAULT
);

  logic                       in_ready;
  logic                       in_valid;
  logic [N_BYTES*BYTE_W-1:0]  in_bits;
  logic                       out_ready;
  logic                       out_valid;
  logic [BYTE_W-1:0]          out_bits;
  logic                       out_last;

  modport master (
    output in_valid, in_bits, out_ready,
    input  in_ready, out_valid, out_bits, out_last
  );

  modport slave (
    input  in_valid, in_bits, out_ready,
    output in_ready, out_valid, out_bits, out_last
  );

endinterface

// File: rtl/word_to_bytes.sv
// Serializes N_BYTES-wide words into a byte stream, LSB byte first.
// One word drains from cur while the following word waits in nxt, so words stream without bubbles.
module word_to_bytes
  import word_to_bytes_pkg::*;
#(
  parameter int N_BYTES = N_BYTES_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  word_to_bytes_if.slave bus,
  output logic           idle
);

  localparam int            W        = N_BYTES * BYTE_W;
  localparam int            IW       = idx_w(N_BYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_BYTES - 1);

  logic          cur_valid;
  logic [W-1:0]  cur_data;
  logic [IW-1:0] idx;
  logic          nxt_valid;
  logic [W-1:0]  nxt_data;

  logic in_fire;
  logic out_fire;
  logic cur_done;
  logic cur_free;

  // in_ready comes only from registered state, never from out_ready.
  assign bus.in_ready  = ~nxt_valid & ~reset;
  assign bus.out_valid = cur_valid;
  assign bus.out_bits  = cur_data[BYTE_W-1:0];
  assign bus.out_last  = cur_valid & (idx == LAST_IDX);
  assign idle          = ~cur_valid & ~nxt_valid;

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = cur_valid & bus.out_ready;
  assign cur_done = out_fire & (idx == LAST_IDX);
  assign cur_free = ~cur_valid | cur_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_valid <= 1'b0;
      cur_data  <= '0;
      idx       <= '0;
      nxt_valid <= 1'b0;
      nxt_data  <= '0;
    end else if (cur_free) begin
      // A prefetched word takes priority; in_ready is low whenever nxt is full.
      if (nxt_valid) begin
        cur_valid <= 1'b1;
        cur_data  <= nxt_data;
        idx       <= '0;
        nxt_valid <= 1'b0;
      end else if (in_fire) begin
        cur_valid <= 1'b1;
        cur_data  <= bus.in_bits;
        idx       <= '0;
      end else begin
        cur_valid <= 1'b0;
      end
    end else begin
      if (out_fire) begin
        cur_data <= cur_data >> BYTE_W;
        idx      <= idx + IW'(1);
      end
      if (in_fire) begin
        nxt_valid <= 1'b1;
        nxt_data  <= bus.in_bits;
      end
    end
  end

endmodule
